// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWRITE= 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_JALR_PC = 4'd12,
    S_LUI     = 4'd13,
    S_AUIPC   = 4'd14,
    S_TRAP    = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    ACLS_ADD, ACLS_RTYPE, ACLS_ITYPE, ACLS_BRANCH, ACLS_LUI
  } alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [9:0] ALU_ADD  = 10'd0;
  localparam logic [9:0] ALU_SUB  = 10'h100;
  localparam logic [9:0] ALU_BEQ  = 10'd8;
  localparam logic [9:0] ALU_BNE  = 10'd9;
  localparam logic [9:0] ALU_BLT  = 10'd10;
  localparam logic [9:0] ALU_BGE  = 10'd11;
  localparam logic [9:0] ALU_BLTU = 10'd12;
  localparam logic [9:0] ALU_BGEU = 10'd13;
  localparam logic [9:0] ALU_LUI  = 10'd14;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEM       = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // funct3 010 and 011 are not defined branch conditions
  function automatic logic branch_funct3_ok(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// Combinational ALU op decode from the instruction class selected by the FSM
// plus funct3/funct7b5.
module alu_op_decoder
  import multicycle_pkg::*;
(
  input  alu_class_t  i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  output logic [9:0]  o_alu_control
);

  logic w_imm_f7b5;
  // Only the immediate arithmetic shift carries meaning in IR[30].
  assign w_imm_f7b5 = (i_funct3 == 3'b101) & i_funct7b5;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and a latch is never inferred.
    o_alu_control = ALU_ADD;
    case (i_class)
      ACLS_RTYPE:  o_alu_control = {1'b0, i_funct7b5, 5'b0, i_funct3};
      ACLS_ITYPE:  o_alu_control = {1'b0, w_imm_f7b5, 5'b0, i_funct3};
      ACLS_BRANCH: begin
        case (i_funct3)
          3'b000:  o_alu_control = ALU_BEQ;
          3'b001:  o_alu_control = ALU_BNE;
          3'b100:  o_alu_control = ALU_BLT;
          3'b101:  o_alu_control = ALU_BGE;
          3'b110:  o_alu_control = ALU_BLTU;
          3'b111:  o_alu_control = ALU_BGEU;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      ACLS_LUI:    o_alu_control = ALU_LUI;
      default:     o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle RV32I controller: state register plus output decode
// (Moore, with mem_ready gating and branch pc_write as the Mealy terms).
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic [9:0]  alu_control,
  output logic        illegal,
  output logic        instr_done,
  output logic [3:0]  state
);

  state_t     r_state;
  alu_class_t w_alu_class;
  logic       w_is_load;

  assign w_is_load = (opcode == OP_LOAD);
  assign state     = r_state;

  // NOTE: state uses non-blocking assignment so every flop samples pre-edge
  // values; the reset is asynchronous, so it sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI:            r_state <= S_LUI;
            OP_AUIPC:          r_state <= S_AUIPC;
            default:           r_state <= S_TRAP;
          endcase
        end
        S_MEMADR:   r_state <= w_is_load ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_MEMWB, S_ALUWB: r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL, S_JALR_PC, S_LUI, S_AUIPC:
                    r_state <= S_ALUWB;
        S_JALR:     r_state <= S_JALR_PC;
        S_BRANCH:   r_state <= branch_funct3_ok(funct3) ? S_FETCH : S_TRAP;
        default:    r_state <= r_state;
      endcase
    end
  end

  // Outputs are forced quiet while reset is high, which also kills any
  // in-flight memory strobe the moment reset arrives.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    illegal     = 1'b0;
    instr_done  = 1'b0;
    w_alu_class = ACLS_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = w_is_load ? IMM_I : IMM_S;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RS1;
          w_alu_class = ACLS_RTYPE;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          w_alu_class = ACLS_ITYPE;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = SRCA_RS1;
          w_alu_class = ACLS_BRANCH;
          if (branch_funct3_ok(funct3)) begin
            pc_write   = zero;
            instr_done = 1'b1;
          end
        end
        S_JAL, S_JALR_PC: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_LUI: begin
          alu_src_b   = SRCB_IMM;
          imm_src     = IMM_U;
          w_alu_class = ACLS_LUI;
        end
        S_AUIPC: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  alu_op_decoder u_alu_op_decoder (
    .i_class       (w_alu_class),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle comparison of every
// output against hand-written expectations for each instruction class.
module tb_multicycle_control_fsm;

  localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2,
    T_MEMREAD = 4'd3, T_MEMWB = 4'd4, T_MEMWRITE = 4'd5, T_EXECR = 4'd6,
    T_EXECI = 4'd7, T_ALUWB = 4'd8, T_BRANCH = 4'd9, T_JAL = 4'd10,
    T_JALR = 4'd11, T_JALR_PC = 4'd12, T_LUI = 4'd13, T_AUIPC = 4'd14,
    T_TRAP = 4'd15;

  typedef struct packed {
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [9:0] alu_control;
    logic       illegal, instr_done;
    logic [3:0] state;
  } obs_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
  logic illegal, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [9:0] alu_control;
  logic [3:0] state;
  obs_t obs;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  assign obs = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control,
                illegal, instr_done, state};

  function automatic obs_t base(input logic [3:0] st);
    obs_t e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t e = base(T_FETCH);
    e.mem_req = 1'b1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
    e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction

  function automatic obs_t e_decode();
    obs_t e = base(T_DECODE);
    e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.imm_src = 3'd2;
    return e;
  endfunction

  function automatic obs_t e_memadr(input logic [2:0] imm);
    obs_t e = base(T_MEMADR);
    e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; e.imm_src = imm;
    return e;
  endfunction

  function automatic obs_t e_memwrite(input logic rdy);
    obs_t e = base(T_MEMWRITE);
    e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; e.instr_done = rdy;
    return e;
  endfunction

  function automatic obs_t e_aluwb();
    obs_t e = base(T_ALUWB);
    e.reg_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1; mem_ready = 1'b1;
    #1 n_vec++;
    if (obs !== obs_t'('0)) begin
      n_err++; $display("FAIL reset_async got=%h exp=%h", obs, obs_t'('0));
    end
    repeat (2) @(posedge clk);
    #1 n_vec++;
    if (obs !== obs_t'('0)) begin
      n_err++; $display("FAIL reset_held got=%h exp=%h", obs, obs_t'('0));
    end
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_add();
    obs_t exp[$]; obs_t e;
    set_instr(7'b0110011, 3'b000, 1'b0);
    exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
    e = base(T_EXECR); e.alu_src_a = 2'd2; exp.push_back(e);
    exp.push_back(e_aluwb());
    foreach (exp[i]) begin
      mem_ready = 1'b1; #1 n_vec++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (state !== T_FETCH) begin
      n_err++; $display("FAIL add_len state=%0d exp=%0d", state, T_FETCH);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [4] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011};
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b101, 3'b101};
    logic       f7s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0] alus[4] = '{10'h100, 10'h000, 10'h105, 10'h005};
    obs_t exp[$]; obs_t e;
    for (int k = 0; k < 4; k++) begin
      exp.delete();
      set_instr(ops[k], f3s[k], f7s[k]);
      exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
      e = base(k == 0 ? T_EXECR : T_EXECI);
      e.alu_src_a = 2'd2; e.alu_src_b = (k == 0) ? 2'd0 : 2'd1;
      e.alu_control = alus[k];
      exp.push_back(e); exp.push_back(e_aluwb());
      foreach (exp[i]) begin
        mem_ready = 1'b1; #1 n_vec++;
        if (obs !== exp[i]) begin
          n_err++; $display("FAIL aluop%0d cyc%0d got=%h exp=%h", k, i, obs, exp[i]);
        end
        @(posedge clk); #1;
      end
      n_vec++;
      if (state !== T_FETCH) begin
        n_err++; $display("FAIL aluop%0d_len state=%0d exp=%0d", k, state, T_FETCH);
      end
    end
  endtask

  task automatic test_load_wait();
    obs_t exp[$]; obs_t e;
    logic rdy[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_instr(7'b0000011, 3'b010, 1'b0);
    exp.push_back(e_fetch(1'b0)); exp.push_back(e_fetch(1'b0));
    exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
    exp.push_back(e_memadr(3'd0));
    e = base(T_MEMREAD); e.mem_req = 1'b1; e.adr_src = 1'b1;
    repeat (3) exp.push_back(e);
    e = base(T_MEMWB); e.result_src = 2'd1; e.reg_write = 1'b1; e.instr_done = 1'b1;
    exp.push_back(e);
    foreach (exp[i]) begin
      mem_ready = rdy[i]; #1 n_vec++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (state !== T_FETCH) begin
      n_err++; $display("FAIL lw_len state=%0d exp=%0d", state, T_FETCH);
    end
  endtask

  task automatic test_store();
    obs_t exp[$];
    set_instr(7'b0100011, 3'b010, 1'b0);
    exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
    exp.push_back(e_memadr(3'd1)); exp.push_back(e_memwrite(1'b1));
    foreach (exp[i]) begin
      mem_ready = 1'b1; #1 n_vec++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL sw cyc%0d got=%h exp=%h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (state !== T_FETCH) begin
      n_err++; $display("FAIL sw_len state=%0d exp=%0d", state, T_FETCH);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b111, 3'b100, 3'b001};
    logic       zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] alus[5] = '{10'd8, 10'd8, 10'd13, 10'd10, 10'd9};
    obs_t exp[$]; obs_t e;
    for (int k = 0; k < 5; k++) begin
      exp.delete();
      set_instr(7'b1100011, f3s[k], 1'b0); zero = zs[k];
      exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
      e = base(T_BRANCH); e.alu_src_a = 2'd2; e.alu_control = alus[k];
      e.pc_write = zs[k]; e.instr_done = 1'b1;
      exp.push_back(e);
      foreach (exp[i]) begin
        mem_ready = 1'b1; #1 n_vec++;
        if (obs !== exp[i]) begin
          n_err++; $display("FAIL br%0d cyc%0d got=%h exp=%h", k, i, obs, exp[i]);
        end
        @(posedge clk); #1;
      end
      n_vec++;
      if (state !== T_FETCH) begin
        n_err++; $display("FAIL br%0d_len state=%0d exp=%0d", k, state, T_FETCH);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    obs_t exp[$]; obs_t e;
    for (int k = 0; k < 4; k++) begin
      exp.delete();
      exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
      case (k)
        0: begin
          set_instr(7'b1101111, 3'b000, 1'b0);
          e = base(T_JAL); e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.pc_write = 1'b1;
          exp.push_back(e);
        end
        1: begin
          set_instr(7'b1100111, 3'b000, 1'b0);
          e = base(T_JALR); e.alu_src_a = 2'd2; e.alu_src_b = 2'd1;
          exp.push_back(e);
          e = base(T_JALR_PC); e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.pc_write = 1'b1;
          exp.push_back(e);
        end
        2: begin
          set_instr(7'b0110111, 3'b000, 1'b0);
          e = base(T_LUI); e.alu_src_b = 2'd1; e.imm_src = 3'd3; e.alu_control = 10'd14;
          exp.push_back(e);
        end
        default: begin
          set_instr(7'b0010111, 3'b000, 1'b0);
          e = base(T_AUIPC); e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.imm_src = 3'd3;
          exp.push_back(e);
        end
      endcase
      exp.push_back(e_aluwb());
      foreach (exp[i]) begin
        mem_ready = 1'b1; #1 n_vec++;
        if (obs !== exp[i]) begin
          n_err++; $display("FAIL jump%0d cyc%0d got=%h exp=%h", k, i, obs, exp[i]);
        end
        @(posedge clk); #1;
      end
      n_vec++;
      if (state !== T_FETCH) begin
        n_err++; $display("FAIL jump%0d_len state=%0d exp=%0d", k, state, T_FETCH);
      end
    end
  endtask

  task automatic test_trap();
    obs_t exp[$]; obs_t e;
    set_instr(7'h7F, 3'b000, 1'b0);
    exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
    e = base(T_TRAP); e.illegal = 1'b1;
    repeat (10) exp.push_back(e);
    foreach (exp[i]) begin
      mem_ready = 1'b1; #1 n_vec++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL trap cyc%0d got=%h exp=%h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1 n_vec++;
    if (obs !== obs_t'('0)) begin
      n_err++; $display("FAIL trap_reset got=%h exp=%h", obs, obs_t'('0));
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    #1 n_vec++;
    if (obs !== e_fetch(1'b0)) begin
      n_err++; $display("FAIL trap_release got=%h exp=%h", obs, e_fetch(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midwrite();
    obs_t exp[$];
    set_instr(7'b0100011, 3'b010, 1'b0);
    exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
    exp.push_back(e_memadr(3'd1));
    foreach (exp[i]) begin
      mem_ready = 1'b1; #1 n_vec++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL rstwr cyc%0d got=%h exp=%h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1 n_vec++;
    if (obs !== e_memwrite(1'b0)) begin
      n_err++; $display("FAIL rstwr_stall got=%h exp=%h", obs, e_memwrite(1'b0));
    end
    reset = 1'b1;
    #1 n_vec++;
    if (obs !== obs_t'('0)) begin
      n_err++; $display("FAIL rstwr_abort got=%h exp=%h", obs, obs_t'('0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp.delete();
    exp.push_back(e_fetch(1'b1)); exp.push_back(e_decode());
    exp.push_back(e_memadr(3'd1)); exp.push_back(e_memwrite(1'b1));
    foreach (exp[i]) begin
      mem_ready = 1'b1; #1 n_vec++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL rstwr_resume cyc%0d got=%h exp=%h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (state !== T_FETCH) begin
      n_err++; $display("FAIL rstwr_len state=%0d exp=%0d", state, T_FETCH);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load_wait();
    test_store();
    test_branch();
    test_jumps();
    test_trap();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
